score_sprite_reader: RTL

//  Read-side client of the initialized digit-glyph SRAM (score.mem). Keeps a 4-digit BCD

---
 rtl/score_sprite_reader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/score_sprite_reader.sv
// Score overlay reader: keeps a 4-digit BCD score, latches it per frame, and fetches
// glyph texels from the digit SRAM on a fixed 2-cycle pixel pipeline.
module score_sprite_reader #(
  parameter int                    DATA_WIDTH = 12,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DIGIT_W    = 16,
  parameter int                    DIGIT_H    = 32,
  parameter int                    X0         = 16,
  parameter int                    Y0         = 16,
  parameter logic [DATA_WIDTH-1:0] TRANSP     = 'h0F0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  score_inc,
  input  logic                  score_clr,
  input  logic                  frame_start,
  input  logic                  pixel_req,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  pix_valid,
  output logic                  pix_hit,
  output logic [DATA_WIDTH-1:0] pix_rgb,
  output logic [15:0]           score_bcd
);

  localparam int CW = $clog2(DIGIT_W);
  localparam int RW = $clog2(DIGIT_H);
  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + 4 * DIGIT_W);
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + DIGIT_H);

  logic [15:0]           live_q, live_d;
  logic [15:0]           disp_q, disp_d;
  logic                  carry;

  logic                  in_box;
  logic [CW+1:0]         dx;
  logic [RW-1:0]         dy;
  logic [1:0]            digit_k;
  logic [3:0]            glyph;
  logic                  blank;
  logic [ADDR_WIDTH-1:0] addr_calc;

  logic                  en1_q, en1_d;
  logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
  logic                  valid1_q, valid1_d;
  logic                  valid2_q, valid2_d;
  logic                  draw2_q, draw2_d;

  // Live score: clear wins over increment; increment saturates at 9999.
  always_comb begin
    live_d = live_q;
    carry  = 1'b1;
    if (score_clr) begin
      live_d = '0;
    end else if (score_inc && (live_q != 16'h9999)) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (live_q[i*4 +: 4] == 4'd9) begin
            live_d[i*4 +: 4] = 4'd0;
          end else begin
            live_d[i*4 +: 4] = live_q[i*4 +: 4] + 4'd1;
            carry            = 1'b0;
          end
        end
      end
    end
    disp_d = frame_start ? live_q : disp_q;
  end

  // Low bits of the offset are exact inside the box, which is all that matters.
  always_comb begin
    in_box  = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI) &&
              ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);
    dx      = pixel_x[CW+1:0] - X_LO[CW+1:0];
    dy      = pixel_y[RW-1:0] - Y_LO[RW-1:0];
    digit_k = dx[CW+1:CW];
    glyph   = 4'd0;
    blank   = 1'b0;
    case (digit_k)
      2'd0: begin
        glyph = disp_q[15:12];
        blank = (disp_q[15:12] == 4'd0);
      end
      2'd1: begin
        glyph = disp_q[11:8];
        blank = (disp_q[15:8] == 8'd0);
      end
      2'd2: begin
        glyph = disp_q[7:4];
        blank = (disp_q[15:4] == 12'd0);
      end
      default: begin
        glyph = disp_q[3:0];
        blank = 1'b0;
      end
    endcase
    addr_calc = (ADDR_WIDTH'(glyph) << (CW + RW)) |
                (ADDR_WIDTH'(dy) << CW) |
                ADDR_WIDTH'(dx[CW-1:0]);
  end

  // Pipeline carries no backpressure: a pixel_req accepted at an edge always emerges
  // with pix_valid exactly two edges later, one pixel per cycle.
  always_comb begin
    en1_d    = pixel_req & in_box & ~blank;
    addr1_d  = en1_d ? addr_calc : addr1_q;
    valid1_d = pixel_req;
    valid2_d = valid1_q;
    draw2_d  = en1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q   <= '0;
      disp_q   <= '0;
      en1_q    <= 1'b0;
      addr1_q  <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      draw2_q  <= 1'b0;
    end else begin
      live_q   <= live_d;
      disp_q   <= disp_d;
      en1_q    <= en1_d;
      addr1_q  <= addr1_d;
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
      draw2_q  <= draw2_d;
    end
  end

  // sram_rdata is the SRAM's own output register, aligned with the stage-2 flags.
  assign sram_en   = en1_q;
  assign sram_we   = 1'b0;
  assign sram_addr = addr1_q;
  assign pix_valid = valid2_q;
  assign pix_hit   = draw2_q & (sram_rdata != TRANSP);
  assign pix_rgb   = pix_hit ? sram_rdata : '0;
  assign score_bcd = live_q;

endmodule
